plab2_proc_pipe_ctrl_scoreboard: RTL and testbench
==================================================

// Module: plab2_proc_pipe_ctrl_scoreboard
// PURPOSE
//  Parametrised N-stage pipeline control for the plab2 processors: per-stage valid/stall/squash
//  sequencing plus a destination-register scoreboard that chooses bypass vs. stall for decode.
//  Sits between the fetch unit and the datapath; replaces per-design hand-written stage chains.
//  Adds full bypass selection and per-stage bypass readiness, so loads and ALU ops share one rule.
// PARAMETERS
//  p_nstages  5  pipeline depth, stage 0 = F, stage N-1 = W; legal range 3..8
//  p_dstage   1  index of decode stage (operand read); 1 <= p_dstage <= p_nstages-2
//  p_aw       5  register-specifier width
// PORTS
//  clk           in   1        clock
//  reset         in   1        asynchronous, active-high
//  in_val        in   1        fetch has an instruction for stage 0
//  in_rdy        out  1        stage 0 accepts this cycle (= !ostall[0])
//  in_drop       out  1        incoming fetch response must be discarded (squash into stage 0)
//  stall_req     in   N        per-stage local stall request (ignored when val[i]=0)
//  squash_req    in   N        per-stage squash of all younger stages (ignored when val[i]=0)
//  byp_ok        in   N        result of stage i available for bypass this cycle
//  d_rs_en/d_rt_en in 1        decode instruction reads rs / rt
//  d_rs/d_rt     in   p_aw     decode source specifiers
//  d_rf_wen      in   1        decode instruction writes RF
//  d_rf_waddr    in   p_aw     decode destination
//  val           out  N        instruction in stage i is live
//  go            out  N        instruction in stage i advances this cycle
//  reg_en        out  N        stage-i pipeline register enable
//  rs_byp_sel    out  N        one-hot bypass source for rs; all-zero = register file
//  rt_byp_sel    out  N        one-hot bypass source for rt; all-zero = register file
//  stall_hazard  out  1        decode stalled on unresolved RAW hazard
//  wb_wen        out  1        last-stage RF write enable (val-qualified)
//  wb_waddr      out  p_aw     last-stage RF write address
// BEHAVIOUR
//  Reset (async): val=0, wen tags=0; hence go=0, reg_en=all 1, in_rdy=1, in_drop=0,
//   byp sels=0, stall_hazard=0, wb_wen=0. Reset mid-stream clears every stage immediately.
//  lstall[i] = val[i] & (stall_req[i] | (i==p_dstage & stall_hazard)).
//  ostall[i] = lstall[i] | ostall[i+1]; ostall[N]=0 (stall propagates to all older stages).
//  sq_in[i]  = OR over j>i of (val[j] & squash_req[j]); squash wins over any stall.
//  go[i] = val[i] & !ostall[i] & !sq_in[i]; go[N-1] retires.  reg_en[i] = !ostall[i].
//  Next val: i=0: sq_in[0] ? 0 : (!ostall[0] ? in_val : hold).  in_drop = sq_in[0].
//   i>0: sq_in[i] ? 0 : (!ostall[i] ? go[i-1] : hold). Squashed stall leaves a bubble, not a hold.
//  Tags (stages i>p_dstage): wen/waddr captured when reg_en[i]; source is d_* inputs for
//   i=p_dstage+1 (loaded as d_rf_wen & go[p_dstage]), else tag of stage i-1.
//  live[i] = val[i] & wen_tag[i] & (waddr_tag[i] != 0); r0 never matches.
//  Per source s (rs/rt, gated by s_en & val[p_dstage]): m = youngest i>p_dstage with live[i]
//   and waddr_tag[i]==s. No match -> sel=0. Match & byp_ok[m] -> sel=onehot(m). Match &
//   !byp_ok[m] -> stall_hazard=1, sel=0. Older matches are shadowed by the youngest.
//  No bubble-insertion logic beyond the above: hazard stall of D yields val[p_dstage+1]=0 next cycle.
//  Stage N-1 is a bypass candidate like any other (RF write-then-read not assumed).
//  wb_wen = live[N-1] & !ostall[N-1]; wb_waddr = waddr_tag[N-1].
//  All outputs combinational from state + inputs; 0-cycle control latency, 1 cycle per stage.
// TESTING
//  1 reset, in_val=1, no stalls -> val fills 1 stage/cycle, val=5'b11111 at cycle 5, go=all 1.
//  2 A: wen r3 in X, byp_ok[2]=1; B reads rs=r3 in D -> rs_byp_sel=5'b00100, stall_hazard=0.
//  3 load-use: A wen r3, byp_ok[2]=0 -> stall_hazard=1, reg_en[1:0]=0, val[2]=0 next cycle;
//    then A in M with byp_ok[3]=1 -> rs_byp_sel=5'b01000, D advances.
//  4 squash_req[2]=1 with val[2]=1 -> in_drop=1, val[1:0]=0 next cycle, val[3]=1 (A advances).
//  5 stall_req[4]=1, val[4]=1 -> reg_en=0, val held, wb_wen=0; same with val[4]=0 -> ignored.
//  6 A wen r0 ahead of B reading r0 -> no match, no stall; assert reset mid-stream -> val=0 at once.

Source files
------------

// File: rtl/plab2_proc_pipe_ctrl_scoreboard.sv
// N-stage pipeline control: per-stage valid/stall/squash sequencing plus a
// destination-register scoreboard that picks bypass or stall for decode operands.
module plab2_proc_pipe_ctrl_scoreboard #(
    parameter int p_nstages = 5,
    parameter int p_dstage  = 1,
    parameter int p_aw      = 5
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_val,
    output logic                 in_rdy,
    output logic                 in_drop,
    input  logic [p_nstages-1:0] stall_req,
    input  logic [p_nstages-1:0] squash_req,
    input  logic [p_nstages-1:0] byp_ok,
    input  logic                 d_rs_en,
    input  logic                 d_rt_en,
    input  logic [p_aw-1:0]      d_rs,
    input  logic [p_aw-1:0]      d_rt,
    input  logic                 d_rf_wen,
    input  logic [p_aw-1:0]      d_rf_waddr,
    output logic [p_nstages-1:0] val,
    output logic [p_nstages-1:0] go,
    output logic [p_nstages-1:0] reg_en,
    output logic [p_nstages-1:0] rs_byp_sel,
    output logic [p_nstages-1:0] rt_byp_sel,
    output logic                 stall_hazard,
    output logic                 wb_wen,
    output logic [p_aw-1:0]      wb_waddr
);

    localparam int N = p_nstages;
    localparam int D = p_dstage;

    // Destination tags exist only for stages past decode.
    logic [N-1:D+1]  wen_tag;
    logic [p_aw-1:0] waddr_tag [D+1:N-1];
    logic [N-1:D+1]  live;

    logic [N-1:0] lstall;
    logic [N:0]   ostall;
    logic [N-1:0] sq_in;
    logic         rs_haz;
    logic         rt_haz;

    // Stage 0 never squashes anyone and stages up to decode are never bypass sources.
    logic unused_ok;
    assign unused_ok = &{1'b0, squash_req[0], byp_ok[D:0]};

    // Youngest matching producer wins; a not-ready youngest match shadows ready older ones.
    function automatic logic [N:0] byp_lookup(input logic en, input logic [p_aw-1:0] src);
        logic [N-1:0] sel;
        logic         haz;
        logic         hit;
        sel = '0;
        haz = 1'b0;
        hit = 1'b0;
        for (int i = D + 1; i < N; i++) begin
            if (!hit && en && live[i] && (waddr_tag[i] == src)) begin
                hit = 1'b1;
                if (byp_ok[i]) sel[i] = 1'b1;
                else           haz    = 1'b1;
            end
        end
        return {haz, sel};
    endfunction

    always_comb begin
        for (int i = D + 1; i < N; i++) begin
            live[i] = val[i] & wen_tag[i] & (waddr_tag[i] != '0);
        end
    end

    always_comb begin
        {rs_haz, rs_byp_sel} = byp_lookup(d_rs_en & val[D], d_rs);
        {rt_haz, rt_byp_sel} = byp_lookup(d_rt_en & val[D], d_rt);
        stall_hazard         = rs_haz | rt_haz;
    end

    always_comb begin
        ostall[N]  = 1'b0;
        sq_in[N-1] = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            lstall[i] = val[i] & (stall_req[i] | ((i == D) ? stall_hazard : 1'b0));
            ostall[i] = lstall[i] | ostall[i+1];
        end
        for (int i = N - 2; i >= 0; i--) begin
            sq_in[i] = sq_in[i+1] | (val[i+1] & squash_req[i+1]);
        end
        for (int i = 0; i < N; i++) begin
            go[i]     = val[i] & ~ostall[i] & ~sq_in[i];
            reg_en[i] = ~ostall[i];
        end
        in_rdy   = ~ostall[0];
        in_drop  = sq_in[0];
        wb_wen   = live[N-1] & ~ostall[N-1];
        wb_waddr = waddr_tag[N-1];
    end

    // A squashed stage becomes a bubble even if it was stalled.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            val     <= '0;
            wen_tag <= '0;
        end else begin
            for (int i = 0; i < N; i++) begin
                if (sq_in[i])        val[i] <= 1'b0;
                else if (!ostall[i]) val[i] <= (i == 0) ? in_val : go[(i == 0) ? 0 : i - 1];
            end
            if (reg_en[D+1]) wen_tag[D+1] <= d_rf_wen & go[D];
            for (int i = D + 2; i < N; i++) begin
                if (reg_en[i]) wen_tag[i] <= wen_tag[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reg_en[D+1]) waddr_tag[D+1] <= d_rf_waddr;
        for (int i = D + 2; i < N; i++) begin
            if (reg_en[i]) waddr_tag[i] <= waddr_tag[i-1];
        end
    end

endmodule

// File: tb/tb_plab2_proc_pipe_ctrl_scoreboard.sv
// Bench for plab2_proc_pipe_ctrl_scoreboard: directed scenarios with fixed expectations,
// then randomized traffic against an instruction-record pipeline model.
module tb_plab2_proc_pipe_ctrl_scoreboard;

    localparam int N  = 5;
    localparam int D  = 1;
    localparam int AW = 5;

    logic          clk = 1'b0;
    logic          reset;
    logic          in_val;
    logic          in_rdy;
    logic          in_drop;
    logic [N-1:0]  stall_req;
    logic [N-1:0]  squash_req;
    logic [N-1:0]  byp_ok;
    logic          d_rs_en;
    logic          d_rt_en;
    logic [AW-1:0] d_rs;
    logic [AW-1:0] d_rt;
    logic          d_rf_wen;
    logic [AW-1:0] d_rf_waddr;
    logic [N-1:0]  val;
    logic [N-1:0]  go;
    logic [N-1:0]  reg_en;
    logic [N-1:0]  rs_byp_sel;
    logic [N-1:0]  rt_byp_sel;
    logic          stall_hazard;
    logic          wb_wen;
    logic [AW-1:0] wb_waddr;

    int n_checks = 0;
    int n_pass   = 0;

    plab2_proc_pipe_ctrl_scoreboard #(.p_nstages(N), .p_dstage(D), .p_aw(AW)) dut (
        .clk(clk), .reset(reset), .in_val(in_val), .in_rdy(in_rdy), .in_drop(in_drop),
        .stall_req(stall_req), .squash_req(squash_req), .byp_ok(byp_ok),
        .d_rs_en(d_rs_en), .d_rt_en(d_rt_en), .d_rs(d_rs), .d_rt(d_rt),
        .d_rf_wen(d_rf_wen), .d_rf_waddr(d_rf_waddr),
        .val(val), .go(go), .reg_en(reg_en), .rs_byp_sel(rs_byp_sel), .rt_byp_sel(rt_byp_sel),
        .stall_hazard(stall_hazard), .wb_wen(wb_wen), .wb_waddr(wb_waddr)
    );

    always #5 clk = ~clk;

    // Model: each stage holds an instruction record (valid, writes-RF, dest).
    bit            mv [N];
    bit            mw [N];
    logic [AW-1:0] ma [N];
    logic [N-1:0]  e_rs, e_rt, e_go, e_regen, e_ost, e_sq;
    bit            e_haz, e_inrdy, e_drop, e_wbwen;
    logic [AW-1:0] e_wbwa;

    function automatic void lookup(input bit en, input logic [AW-1:0] src,
                                   output logic [N-1:0] sel, output bit haz);
        sel = '0;
        haz = 1'b0;
        if (en) begin
            for (int i = D + 1; i < N; i++) begin
                if (mv[i] && mw[i] && ma[i] != 0 && ma[i] == src) begin
                    if (byp_ok[i]) sel[i] = 1'b1;
                    else           haz    = 1'b1;
                    break;
                end
            end
        end
    endfunction

    function automatic void model_eval();
        bit hr, ht;
        int hs, sqi;
        lookup(d_rs_en && mv[D], d_rs, e_rs, hr);
        lookup(d_rt_en && mv[D], d_rt, e_rt, ht);
        e_haz = hr | ht;
        hs  = -1;
        sqi = -1;
        for (int j = 0; j < N; j++) begin
            if (mv[j] && (stall_req[j] || (j == D && e_haz))) hs = j;
            if (mv[j] && squash_req[j]) sqi = j;
        end
        for (int i = 0; i < N; i++) begin
            e_ost[i]   = (i <= hs);
            e_sq[i]    = (i < sqi);
            e_go[i]    = mv[i] && !e_ost[i] && !e_sq[i];
            e_regen[i] = !e_ost[i];
        end
        e_inrdy = !e_ost[0];
        e_drop  = e_sq[0];
        e_wbwen = mv[N-1] && mw[N-1] && ma[N-1] != 0 && !e_ost[N-1];
        e_wbwa  = ma[N-1];
    endfunction

    function automatic void model_update();
        bit            nv [N];
        bit            nw [N];
        logic [AW-1:0] na [N];
        for (int i = 0; i < N; i++) begin
            nv[i] = mv[i]; nw[i] = mw[i]; na[i] = ma[i];
            if (e_sq[i]) nv[i] = 1'b0;
            else if (!e_ost[i]) begin
                if (i == 0) nv[0] = in_val;
                else if (e_go[i-1]) begin
                    nv[i] = 1'b1;
                    if (i == D + 1) begin nw[i] = d_rf_wen; na[i] = d_rf_waddr; end
                    else            begin nw[i] = mw[i-1];  na[i] = ma[i-1];    end
                end else nv[i] = 1'b0;
            end
        end
        for (int i = 0; i < N; i++) begin mv[i] = nv[i]; mw[i] = nw[i]; ma[i] = na[i]; end
    endfunction

    task automatic clear_inputs();
        in_val = 0; stall_req = '0; squash_req = '0; byp_ok = '0;
        d_rs_en = 0; d_rt_en = 0; d_rs = '0; d_rt = '0; d_rf_wen = 0; d_rf_waddr = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        clear_inputs();
        reset = 1'b1;
        for (int i = 0; i < N; i++) begin mv[i] = 0; mw[i] = 0; ma[i] = '0; end
        tick();
        reset = 1'b0;
        tick();
    endtask

    task automatic fill(input int k);
        in_val = 1'b1;
        repeat (k) tick();
    endtask

    task automatic test_reset();
        clear_inputs();
        reset = 1'b1;
        #2;
        n_checks++;
        if ({val, go, reg_en, in_rdy, in_drop, rs_byp_sel, rt_byp_sel, stall_hazard, wb_wen} !==
            {5'b0, 5'b0, 5'b11111, 1'b1, 1'b0, 5'b0, 5'b0, 1'b0, 1'b0})
            $display("FAIL reset_state val=%b go=%b reg_en=%b rdy=%b drop=%b haz=%b wb=%b required 0/0/11111/1/0/0/0",
                     val, go, reg_en, in_rdy, in_drop, stall_hazard, wb_wen);
        else n_pass++;
        tick();
        reset = 1'b0;
        tick();
    endtask

    task automatic test_fill();
        do_reset();
        in_val = 1'b1;
        for (int c = 1; c <= N; c++) begin
            logic [N-1:0] exp_val;
            tick();
            exp_val = N'((1 << c) - 1);
            n_checks++;
            if (val !== exp_val) $display("FAIL fill_val c=%0d got %b required %b", c, val, exp_val);
            else n_pass++;
        end
        n_checks++;
        if (go !== 5'b11111 || reg_en !== 5'b11111)
            $display("FAIL fill_go got go=%b reg_en=%b required 11111/11111", go, reg_en);
        else n_pass++;
    endtask

    task automatic test_bypass();
        do_reset();
        fill(N);
        d_rf_wen = 1'b1; d_rf_waddr = 5'd3;
        tick();
        d_rs_en = 1'b1; d_rs = 5'd3; d_rt_en = 1'b1; d_rt = 5'd3; byp_ok = 5'b00100;
        #1;
        n_checks++;
        if (rs_byp_sel !== 5'b00100 || rt_byp_sel !== 5'b00100 || stall_hazard !== 1'b0)
            $display("FAIL bypass_x rs=%b rt=%b haz=%b required 00100/00100/0", rs_byp_sel, rt_byp_sel, stall_hazard);
        else n_pass++;
        tick();
        byp_ok = 5'b01100;
        #1;
        n_checks++;
        if (rs_byp_sel !== 5'b00100 || stall_hazard !== 1'b0)
            $display("FAIL bypass_youngest rs=%b haz=%b required 00100/0", rs_byp_sel, stall_hazard);
        else n_pass++;
        byp_ok = 5'b01000;
        #1;
        n_checks++;
        if (rs_byp_sel !== 5'b00000 || stall_hazard !== 1'b1)
            $display("FAIL bypass_shadow rs=%b haz=%b required 00000/1", rs_byp_sel, stall_hazard);
        else n_pass++;
    endtask

    task automatic test_load_use();
        do_reset();
        fill(N);
        d_rf_wen = 1'b1; d_rf_waddr = 5'd3;
        tick();
        d_rf_wen = 1'b0; d_rs_en = 1'b1; d_rs = 5'd3; byp_ok = 5'b00000;
        #1;
        n_checks++;
        if (stall_hazard !== 1'b1 || reg_en !== 5'b11100 || go !== 5'b11100 || rs_byp_sel !== 5'b0)
            $display("FAIL loaduse_stall haz=%b reg_en=%b go=%b rs=%b required 1/11100/11100/00000",
                     stall_hazard, reg_en, go, rs_byp_sel);
        else n_pass++;
        tick();
        byp_ok = 5'b01000;
        #1;
        n_checks++;
        if (val !== 5'b11011 || rs_byp_sel !== 5'b01000 || stall_hazard !== 1'b0 || go !== 5'b11011)
            $display("FAIL loaduse_release val=%b rs=%b haz=%b go=%b required 11011/01000/0/11011",
                     val, rs_byp_sel, stall_hazard, go);
        else n_pass++;
    endtask

    task automatic test_squash();
        do_reset();
        fill(N);
        squash_req = 5'b00100;
        #1;
        n_checks++;
        if (in_drop !== 1'b1 || go !== 5'b11100)
            $display("FAIL squash_comb drop=%b go=%b required 1/11100", in_drop, go);
        else n_pass++;
        tick();
        squash_req = '0;
        #1;
        n_checks++;
        if (val !== 5'b11000) $display("FAIL squash_val got %b required 11000", val);
        else n_pass++;
    endtask

    task automatic test_stall_wb();
        do_reset();
        d_rf_wen = 1'b1; d_rf_waddr = 5'd5;
        fill(N);
        n_checks++;
        if (wb_wen !== 1'b1 || wb_waddr !== 5'd5)
            $display("FAIL wb_live wen=%b waddr=%0d required 1/5", wb_wen, wb_waddr);
        else n_pass++;
        stall_req = 5'b10000;
        #1;
        n_checks++;
        if (reg_en !== 5'b0 || go !== 5'b0 || wb_wen !== 1'b0)
            $display("FAIL wstall reg_en=%b go=%b wb=%b required 00000/00000/0", reg_en, go, wb_wen);
        else n_pass++;
        tick();
        n_checks++;
        if (val !== 5'b11111) $display("FAIL wstall_hold got %b required 11111", val);
        else n_pass++;
        do_reset();
        fill(N - 1);
        stall_req = 5'b10000;
        #1;
        n_checks++;
        if (reg_en !== 5'b11111 || go !== 5'b01111)
            $display("FAIL wstall_ignored reg_en=%b go=%b required 11111/01111", reg_en, go);
        else n_pass++;
    endtask

    task automatic test_r0_and_reset();
        do_reset();
        fill(N);
        d_rf_wen = 1'b1; d_rf_waddr = 5'd0;
        tick();
        d_rf_wen = 1'b0; d_rs_en = 1'b1; d_rs = 5'd0; byp_ok = '0;
        #1;
        n_checks++;
        if (stall_hazard !== 1'b0 || rs_byp_sel !== 5'b0)
            $display("FAIL r0_nomatch haz=%b rs=%b required 0/00000", stall_hazard, rs_byp_sel);
        else n_pass++;
        reset = 1'b1;
        #1;
        n_checks++;
        if (val !== 5'b0 || go !== 5'b0) $display("FAIL midreset val=%b go=%b required 0/0", val, go);
        else n_pass++;
        reset = 1'b0;
        tick();
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 600; c++) begin
            in_val     = ($urandom_range(3) != 0);
            for (int i = 0; i < N; i++) begin
                stall_req[i]  = ($urandom_range(9) == 0);
                squash_req[i] = ($urandom_range(15) == 0);
            end
            byp_ok     = N'($urandom);
            d_rs_en    = $urandom_range(1);
            d_rt_en    = $urandom_range(1);
            d_rs       = AW'($urandom_range(3));
            d_rt       = AW'($urandom_range(3));
            d_rf_wen   = $urandom_range(1);
            d_rf_waddr = AW'($urandom_range(3));
            #1;
            model_eval();
            n_checks++;
            if ({val, go, reg_en, in_rdy, in_drop, rs_byp_sel, rt_byp_sel, stall_hazard, wb_wen} !==
                {e_val_vec(), e_go, e_regen, e_inrdy, e_drop, e_rs, e_rt, e_haz, e_wbwen})
                $display("FAIL rand_c%0d val=%b/%b go=%b/%b reg_en=%b/%b rdy=%b/%b drop=%b/%b rs=%b/%b rt=%b/%b haz=%b/%b wb=%b/%b (actual/required)",
                         c, val, e_val_vec(), go, e_go, reg_en, e_regen, in_rdy, e_inrdy, in_drop, e_drop,
                         rs_byp_sel, e_rs, rt_byp_sel, e_rt, stall_hazard, e_haz, wb_wen, e_wbwen);
            else n_pass++;
            if (e_wbwen) begin
                n_checks++;
                if (wb_waddr !== e_wbwa) $display("FAIL rand_waddr_c%0d got %0d required %0d", c, wb_waddr, e_wbwa);
                else n_pass++;
            end
            @(posedge clk);
            model_update();
            #1;
        end
    endtask

    function automatic logic [N-1:0] e_val_vec();
        logic [N-1:0] v;
        for (int i = 0; i < N; i++) v[i] = mv[i];
        return v;
    endfunction

    initial begin
        reset = 1'b0;
        clear_inputs();
        #1;
        test_reset();
        test_fill();
        test_bypass();
        test_load_use();
        test_squash();
        test_stall_wb();
        test_r0_and_reset();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
